// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master among N_REQ requesters.
// Sequences start/stop strobes, watches m_busy, and returns read data or timeout to the owner.
module i2c_master_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned START_CYCLES = 20,
    parameter int unsigned STOP_CYCLES  = 20,
    parameter int unsigned TIMEOUT      = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_addr,
    input  logic [8*N_REQ-1:0]         req_wdata,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [7:0]                 rsp_data,
    output logic                       rsp_err,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       m_start,
    output logic                       m_stop,
    output logic [7:0]                 m_address,
    output logic [7:0]                 m_data_in,
    input  logic [7:0]                 m_data_out,
    input  logic                       m_busy
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + START_CYCLES + STOP_CYCLES);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] XFER      = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] RESP      = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [ID_W-1:0]  gid_d;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  pick;
    logic             found;

    logic [N_REQ-1:0] req_ready_d;
    logic [N_REQ-1:0] rsp_valid_d;
    logic [7:0]       rsp_data_d;
    logic             rsp_err_d;
    logic             busy_d;
    logic             m_start_d;
    logic             m_stop_d;
    logic [7:0]       m_address_d;
    logic [7:0]       m_data_in_d;

    // Next-state, datapath and output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        data_d      = data_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rr_d        = rr_q;
        gid_d       = grant_id;
        req_ready_d = '0;
        cand        = '0;
        pick        = '0;
        found       = 1'b0;

        // First pending requester at or above the rr pointer, wrapping
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ID_W'((32'(rr_q) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (!m_busy && found) begin
                    req_ready_d = N_REQ'(1) << pick;
                    addr_d      = req_addr[{pick, 3'b000} +: 8];
                    wdata_d     = req_wdata[{pick, 3'b000} +: 8];
                    gid_d       = pick;
                    rr_d        = ID_W'((32'(pick) + 1) % N_REQ);
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    data_d      = 8'h00;
                    state_d     = START;
                end
            end
            START: begin
                if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = WAIT_BUSY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_BUSY: begin
                if (m_busy) begin
                    cnt_d   = '0;
                    state_d = XFER;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            XFER: begin
                if (!m_busy) begin
                    cnt_d   = '0;
                    data_d  = m_data_out;
                    state_d = STOP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_W'(STOP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs registered from next-state so they align with the state they describe
        busy_d      = (state_d != IDLE);
        m_start_d   = (state_d == START);
        m_stop_d    = (state_d == STOP);
        m_address_d = (state_d != IDLE) ? addr_d : 8'h00;
        m_data_in_d = (state_d != IDLE) ? wdata_d : 8'h00;
        rsp_valid_d = (state_d == RESP) ? (N_REQ'(1) << gid_d) : '0;
        rsp_err_d   = (state_d == RESP) && err_d;
        rsp_data_d  = (state_d == RESP && !err_d) ? data_d : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            data_q    <= 8'h00;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            rr_q      <= '0;
            grant_id  <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            m_start   <= 1'b0;
            m_stop    <= 1'b0;
            m_address <= 8'h00;
            m_data_in <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rr_q      <= rr_d;
            grant_id  <= gid_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            busy      <= busy_d;
            m_start   <= m_start_d;
            m_stop    <= m_stop_d;
            m_address <= m_address_d;
            m_data_in <= m_data_in_d;
        end
    end

endmodule
